// File: rtl/osnt_bram_pkg.sv
// rtl/osnt_bram_pkg.sv - entry layout and replay FSM encoding shared by osnt_bram users
package osnt_bram_pkg;

  // One packed entry occupies 64 bytes of BRAM address space.
  localparam int ENTRY_BYTES = 64;
  localparam int WORD_LSB    = $clog2(ENTRY_BYTES);

  // Packed entry field offsets; the host-side loader packs entries the same way.
  localparam int TDATA_LSB = 0;
  localparam int TUSER_LSB = 1024;
  localparam int TKEEP_LSB = 1152;
  localparam int TLAST_BIT = 1280;
  localparam int VALID_BIT = 1281;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2,
    DRAIN    = 2'd3
  } replay_state_t;

endpackage

// File: rtl/osnt_bram_skid.sv
// rtl/osnt_bram_skid.sv - two-entry output buffer with occupancy for the replay stream
module osnt_bram_skid #(
  parameter int WIDTH = 1282
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic             wr_sel;
  logic             rd_sel;

  // Slot storage: writes alternate between the two slots
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0  <= '0;
      slot1  <= '0;
      wr_sel <= 1'b0;
    end else if (push) begin
      if (wr_sel) slot1 <= push_data;
      else        slot0 <= push_data;
      wr_sel <= ~wr_sel;
    end
  end

  // Read pointer and occupancy; push and pop may happen in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_sel    <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      if (pop) rd_sel <= ~rd_sel;
      occupancy <= occupancy + {1'b0, push} - {1'b0, pop};
    end
  end

  // Head stays put while not popped, so beat fields are stable under backpressure
  assign head_data = rd_sel ? slot1 : slot0;

endmodule

// File: rtl/osnt_bram_replay.sv
// rtl/osnt_bram_replay.sv - replays packed BRAM entries as a stream; OSNT_REPLAY_IPG_EN adds an inter-packet gap
module osnt_bram_replay
  import osnt_bram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 1282,
  parameter int TDATA_WIDTH = 1024,
  parameter int TUSER_WIDTH = 128
) (
  input  logic                       bram_clk,
  input  logic                       bram_rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic [ADDR_WIDTH-7:0]      last_word,
  input  logic [31:0]                replay_count,
`ifdef OSNT_REPLAY_IPG_EN
  input  logic [15:0]                ipg_cycles,
`endif
  output logic [ADDR_WIDTH-1:0]      bram_addr_b,
  output logic                       bram_en_b,
  input  logic [DATA_WIDTH-1:0]      bram_rddata_b,
  output logic [TDATA_WIDTH-1:0]     m_axis_tdata,
  output logic [TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic [TDATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       busy,
  output logic [31:0]                loop_cnt,
  output logic [31:0]                pkt_cnt,
  output logic                       err_trunc
);

  localparam int WW = ADDR_WIDTH - WORD_LSB;

  replay_state_t         state;
  replay_state_t         state_nxt;
  logic [WW-1:0]         word_idx;
  logic [WW-1:0]         last_word_q;
  logic [31:0]           replay_q;
  logic                  rd_pending;
  logic                  final_rd;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head;
  logic                  push;
  logic                  pop;
  logic                  ret_tlast;
  logic                  at_wrap;
  logic                  loop_done;
  logic                  credit_ok;
  logic [2:0]            credit_sum;
  logic                  issue_ok;
  logic                  drain_done;
  logic                  start_ok;
  logic                  gap_open;

  // Dropped entries (valid=0) are read but never enter the buffer
  assign push      = rd_pending & bram_rddata_b[VALID_BIT];
  assign ret_tlast = push & bram_rddata_b[TLAST_BIT];
  assign pop       = m_axis_tvalid & m_axis_tready;
  assign start_ok  = (state == IDLE) & start;

  // Occupancy after this cycle's pop plus the read landing now must leave room for a new read
  assign credit_sum = {1'b0, occ} + {2'b0, rd_pending} - {2'b0, pop};
  assign credit_ok  = (credit_sum < 3'd2);

  assign at_wrap    = (word_idx == last_word_q);
  assign loop_done  = at_wrap && (replay_q != 32'd0) && ((loop_cnt + 32'd1) == replay_q);
  assign drain_done = !rd_pending && (occ == 2'd0);

  osnt_bram_skid #(
    .WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (bram_clk),
    .rst       (bram_rst),
    .push      (push),
    .push_data (bram_rddata_b),
    .pop       (pop),
    .head_data (head),
    .occupancy (occ)
  );

  // FSM state register
  always_ff @(posedge bram_clk or posedge bram_rst) begin
    if (bram_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next state; a loop-count end and a stop boundary in the same cycle both land in DRAIN
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (start) state_nxt = RUN;
      RUN: begin
        if (bram_en_b && loop_done) state_nxt = DRAIN;
        else if (stop)              state_nxt = STOPPING;
      end
      STOPPING: if (ret_tlast || (bram_en_b && loop_done)) state_nxt = DRAIN;
      DRAIN:    if (drain_done) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // FSM outputs; once a TLAST entry returns while stopping, the read that would follow is withheld
  always_comb begin
    busy     = (state != IDLE);
    issue_ok = 1'b0;
    unique case (state)
      RUN:      issue_ok = 1'b1;
      STOPPING: issue_ok = !ret_tlast;
      default:  issue_ok = 1'b0;
    endcase
    bram_en_b = issue_ok && credit_ok;
  end

  assign bram_addr_b = {word_idx, {WORD_LSB{1'b0}}};

  // Read issuer: word index walk, config latch and in-flight tracking
  always_ff @(posedge bram_clk or posedge bram_rst) begin
    if (bram_rst) begin
      word_idx    <= '0;
      last_word_q <= '0;
      replay_q    <= '0;
      rd_pending  <= 1'b0;
      final_rd    <= 1'b0;
    end else begin
      rd_pending <= bram_en_b;
      final_rd   <= bram_en_b && loop_done;
      if (start_ok) begin
        word_idx    <= '0;
        last_word_q <= last_word;
        replay_q    <= replay_count;
      end else if (bram_en_b) begin
        word_idx <= at_wrap ? '0 : word_idx + 1'b1;
      end
    end
  end

  // Loop, packet and truncation status; cleared by an accepted start
  always_ff @(posedge bram_clk or posedge bram_rst) begin
    if (bram_rst) begin
      loop_cnt  <= '0;
      pkt_cnt   <= '0;
      err_trunc <= 1'b0;
    end else if (start_ok) begin
      loop_cnt  <= '0;
      pkt_cnt   <= '0;
      err_trunc <= 1'b0;
    end else begin
      if (bram_en_b && at_wrap) loop_cnt <= loop_cnt + 32'd1;
      if (pop && head[TLAST_BIT]) pkt_cnt <= pkt_cnt + 32'd1;
      if (rd_pending && final_rd && !bram_rddata_b[TLAST_BIT]) err_trunc <= 1'b1;
    end
  end

`ifdef OSNT_REPLAY_IPG_EN
  logic [15:0] ipg_q;
  logic [15:0] ipg_cnt;

  // Inter-packet gap: hold tvalid low for ipg_q clocks after each TLAST handshake
  always_ff @(posedge bram_clk or posedge bram_rst) begin
    if (bram_rst) begin
      ipg_q   <= '0;
      ipg_cnt <= '0;
    end else begin
      if (start_ok) ipg_q <= ipg_cycles;
      if ((state == DRAIN) && drain_done) ipg_cnt <= '0;
      else if (pop && head[TLAST_BIT])    ipg_cnt <= ipg_q;
      else if (ipg_cnt != 16'd0)          ipg_cnt <= ipg_cnt - 16'd1;
    end
  end

  assign gap_open = (ipg_cnt == 16'd0);
`else
  assign gap_open = 1'b1;
`endif

  assign m_axis_tvalid = (occ != 2'd0) && head[VALID_BIT] && gap_open;
  assign m_axis_tdata  = head[TDATA_LSB +: TDATA_WIDTH];
  assign m_axis_tuser  = head[TUSER_LSB +: TUSER_WIDTH];
  assign m_axis_tkeep  = head[TKEEP_LSB +: TDATA_WIDTH/8];
  assign m_axis_tlast  = head[TLAST_BIT];

endmodule

// File: tb/tb_osnt_bram_replay.sv
// tb/tb_osnt_bram_replay.sv - randomized scoreboard bench for osnt_bram_replay
`timescale 1ns/1ps
module tb_osnt_bram_replay;

  localparam int AW = 20;
  localparam int DW = 1282;
  localparam int TW = 1024;
  localparam int UW = 128;
  localparam int KW = TW / 8;

  logic            bram_clk = 1'b0;
  logic            bram_rst = 1'b1;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic [AW-7:0]   last_word = '0;
  logic [31:0]     replay_count = '0;
`ifdef OSNT_REPLAY_IPG_EN
  logic [15:0]     ipg_cycles = '0;
`endif
  logic [AW-1:0]   bram_addr_b;
  logic            bram_en_b;
  logic [DW-1:0]   bram_rddata_b = '0;
  logic [TW-1:0]   m_axis_tdata;
  logic [UW-1:0]   m_axis_tuser;
  logic [KW-1:0]   m_axis_tkeep;
  logic            m_axis_tlast;
  logic            m_axis_tvalid;
  logic            m_axis_tready = 1'b1;
  logic            busy;
  logic [31:0]     loop_cnt;
  logic [31:0]     pkt_cnt;
  logic            err_trunc;

  int              n_cmp = 0;
  int              n_bad = 0;
  int              cyc = 0;
  int              ipg_val = 0;
  int              exp_pkts = 0;
  bit              rnd_ready = 1'b0;
  bit              prev_stall = 1'b0;
  logic [DW-2:0]   prev_beat = '0;
  logic [DW-1:0]   mem [16];
  logic [DW-2:0]   got[$];
  logic [DW-2:0]   exp_q[$];
  int              hs[$];
  logic [DW-2:0]   beat_now;

  osnt_bram_replay dut (
    .bram_clk      (bram_clk),
    .bram_rst      (bram_rst),
    .start         (start),
    .stop          (stop),
    .last_word     (last_word),
    .replay_count  (replay_count),
`ifdef OSNT_REPLAY_IPG_EN
    .ipg_cycles    (ipg_cycles),
`endif
    .bram_addr_b   (bram_addr_b),
    .bram_en_b     (bram_en_b),
    .bram_rddata_b (bram_rddata_b),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .loop_cnt      (loop_cnt),
    .pkt_cnt       (pkt_cnt),
    .err_trunc     (err_trunc)
  );

  initial forever #5 bram_clk = ~bram_clk;

  always @(posedge bram_clk) cyc <= cyc + 1;

  // behavioural BRAM port B: one-cycle registered read
  always @(posedge bram_clk) if (bram_en_b) bram_rddata_b <= mem[bram_addr_b[9:6]];

  initial forever begin
    @(posedge bram_clk);
    #1 m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  assign beat_now = {m_axis_tlast, m_axis_tkeep, m_axis_tuser, m_axis_tdata};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sig(input logic [DW-2:0] b);
    logic [63:0]   s;
    logic [1311:0] t;
    s = 64'h0123456789abcdef;
    t = '0;
    t[DW-2:0] = b;
    for (int k = 0; k < 41; k++) s = (s ^ {32'h0, t[k*32 +: 32]}) * 64'h9E3779B97F4A7C15 + 64'(k);
    return s;
  endfunction

  // stream monitor: records handshakes, checks stability under stall
  always @(negedge bram_clk) begin
    if (bram_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("stall_beat", sig(beat_now), sig(prev_beat));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        got.push_back(beat_now);
        hs.push_back(cyc);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = beat_now;
    end
  end

  task automatic set_entry(input int w, input bit last, input bit vld);
    logic [1311:0] t;
    for (int k = 0; k < 41; k++) t[k*32 +: 32] = $urandom;
    mem[w] = {vld, last, t[DW-3:0]};
  endtask

  // reference: entries 0..lw in order, rc times, dropping valid=0 entries
  task automatic build_exp(input int lw, input int rc);
    exp_q.delete();
    exp_pkts = 0;
    for (int l = 0; l < rc; l++)
      for (int w = 0; w <= lw; w++)
        if (mem[w][DW-1]) begin
          exp_q.push_back(mem[w][DW-2:0]);
          if (mem[w][DW-2]) exp_pkts++;
        end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 4000) begin
      @(posedge bram_clk);
      #1 n++;
    end
    check({tag, "_idle"}, 64'(n < 4000), 64'd1);
  endtask

  // mode: 1 = stop with start, 2 = extra start mid-run, 4 = check beat spacing
  task automatic run_check(input string tag, input int lw, input int rc, input int mode);
    build_exp(lw, rc);
    got.delete();
    hs.delete();
    @(posedge bram_clk);
    #1;
    last_word = (AW-6)'(lw);
    replay_count = rc;
`ifdef OSNT_REPLAY_IPG_EN
    ipg_cycles = 16'(ipg_val);
`endif
    start = 1'b1;
    stop = ((mode & 1) != 0);
    @(posedge bram_clk);
    #1 start = 1'b0;
    stop = 1'b0;
    if ((mode & 2) != 0) begin
      repeat (3) @(posedge bram_clk);
      #1 last_word = '0;
      replay_count = 1;
      start = 1'b1;
      @(posedge bram_clk);
      #1 start = 1'b0;
    end
    wait_idle(tag);
    repeat (3) @(posedge bram_clk);
    @(negedge bram_clk);
    check({tag, "_nbeats"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), sig(got[i]), sig(exp_q[i]));
    check({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(exp_pkts));
    check({tag, "_loop_cnt"}, 64'(loop_cnt), 64'(rc));
    check({tag, "_err_trunc"}, 64'(err_trunc), 64'(!mem[lw][DW-2]));
    check({tag, "_tvalid_end"}, 64'(m_axis_tvalid), 64'd0);
    if ((mode & 4) != 0)
      for (int i = 1; i < hs.size() && i < exp_q.size(); i++)
        check($sformatf("%s_spacing%0d", tag, i), 64'(hs[i] - hs[i-1]),
              64'(1 + (exp_q[i-1][DW-2] ? ipg_val : 0)));
  endtask

  initial begin
    int n;
    int lw;
    int rc;
    for (int w = 0; w < 16; w++) set_entry(w, 1'b1, 1'b1);

    // reset state
    repeat (3) @(posedge bram_clk);
    #1;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_en", 64'(bram_en_b), 64'd0);
    check("rst_addr", 64'(bram_addr_b), 64'd0);
    check("rst_loop_cnt", loop_cnt, 64'd0);
    check("rst_pkt_cnt", pkt_cnt, 64'd0);
    check("rst_err", 64'(err_trunc), 64'd0);
    check("rst_tdata", m_axis_tdata[63:0], 64'd0);
    bram_rst = 1'b0;

    // stop while idle is ignored
    @(posedge bram_clk);
    #1 stop = 1'b1;
    @(posedge bram_clk);
    #1 stop = 1'b0;
    @(posedge bram_clk);
    #1 check("idle_stop_busy", 64'(busy), 64'd0);

    // packets of 2, 1, 3 beats
    set_entry(0, 0, 1); set_entry(1, 1, 1); set_entry(2, 1, 1);
    set_entry(3, 0, 1); set_entry(4, 0, 1); set_entry(5, 1, 1);
    rnd_ready = 1'b0;
    run_check("t1", 5, 2, 2 | 4);
    rnd_ready = 1'b1;
    run_check("t2", 5, 2, 0);
    rnd_ready = 1'b0;

    // graceful stop in the middle of the 3-beat packet, infinite replay
    build_exp(5, 40);
    got.delete();
    @(posedge bram_clk);
    #1 last_word = 5;
    replay_count = 0;
    start = 1'b1;
    @(posedge bram_clk);
    #1 start = 1'b0;
    n = 0;
    while (got.size() < 4 && n < 500) begin
      @(posedge bram_clk);
      #1 n++;
    end
    check("t3_reach", 64'(n < 500), 64'd1);
    stop = 1'b1;
    @(posedge bram_clk);
    #1 stop = 1'b0;
    wait_idle("t3");
    n = got.size();
    repeat (5) @(posedge bram_clk);
    #1 check("t3_no_more", 64'(got.size()), 64'(n));
    check("t3_min_beats", 64'(got.size() >= 6), 64'd1);
    if (got.size() > 0) check("t3_ends_tlast", 64'(got[got.size()-1][DW-2]), 64'd1);
    exp_pkts = 0;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      check($sformatf("t3_beat%0d", i), sig(got[i]), sig(exp_q[i]));
      if (exp_q[i][DW-2]) exp_pkts++;
    end
    check("t3_pkt_cnt", pkt_cnt, 64'(exp_pkts));

    // dropped entries
    set_entry(0, 1, 1); set_entry(1, 1, 0); set_entry(2, 1, 1);
    set_entry(3, 1, 0); set_entry(4, 1, 1);
    run_check("t4", 4, 1, 0);

    // truncated final entry, then reset mid-run and replay again
    set_entry(0, 0, 1); set_entry(1, 1, 1); set_entry(2, 0, 1); set_entry(3, 0, 1);
    run_check("t5", 3, 1, 0);
    @(posedge bram_clk);
    #1 last_word = 3;
    replay_count = 0;
    start = 1'b1;
    @(posedge bram_clk);
    #1 start = 1'b0;
    n = 0;
    while (got.size() < 8 && n < 500) begin
      @(posedge bram_clk);
      #1 n++;
    end
    #2 bram_rst = 1'b1;
    #1;
    check("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_pkt_cnt", pkt_cnt, 64'd0);
    check("midrst_loop_cnt", loop_cnt, 64'd0);
    @(posedge bram_clk);
    #3 bram_rst = 1'b0;
    run_check("t5b", 3, 1, 0);

`ifdef OSNT_REPLAY_IPG_EN
    for (int w = 0; w < 4; w++) set_entry(w, 1, 1);
    ipg_val = 4;
    run_check("t6", 3, 2, 4);
    ipg_val = 0;
`endif

    // randomized configurations
    for (int r = 0; r < 6; r++) begin
      lw = (r == 0) ? 0 : int'($urandom_range(1, 7));
      for (int w = 0; w <= lw; w++)
        set_entry(w, 1'($urandom_range(0, 1)), (w == lw) || ($urandom_range(0, 3) != 0));
      rc = int'($urandom_range(1, 3));
      rnd_ready = 1'($urandom_range(0, 1));
      run_check($sformatf("rnd%0d", r), lw, rc, (r == 1) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
